// File: rtl/div_radix2_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// state_dbg mirrors the divider FSM state (0 IDLE, 1 DIV, 2 DONE) for observation.
interface div_radix2_if;
    logic        flush;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_div;
    logic        done;
    logic [63:0] result;
    logic [1:0]  state_dbg;

    modport master (
        output flush, start, signed_div, a, b,
        input  stall_div, done, result, state_dbg
    );

    modport slave (
        input  flush, start, signed_div, a, b,
        output stall_div, done, result, state_dbg
    );
endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring DIV/DIVU unit for the EX stage; result = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips iteration and finishes in one cycle.
module div_radix2 (
    input  logic         clk,
    input  logic         resetn,
    div_radix2_if.slave  bus
);
    // Handshake: start is accepted only in IDLE when flush is low; done pulses
    // for one cycle on entry to DONE, and result holds until the next completion.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [32:0] rem;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sign_q, sign_r;
    logic [63:0] result_q;
    logic        done_q;

    logic        sa, sb;
    logic [31:0] a_mag, b_mag;
    logic [33:0] trial;
    logic        ge;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic        accept;

    assign accept = bus.start && !bus.flush;
    assign sa     = bus.signed_div && bus.a[31];
    assign sb     = bus.signed_div && bus.b[31];
    assign a_mag  = sa ? (32'd0 - bus.a) : bus.a;
    assign b_mag  = sb ? (32'd0 - bus.b) : bus.b;

    always_comb begin
        trial  = {rem, dvd[31]};
        ge     = (trial >= {2'b00, dvs});
        rem_nx = ge ? 33'(trial - {2'b00, dvs}) : trial[32:0];
        quo_nx = {dvd[30:0], ge};
    end

    always_comb begin
        state_nx      = state;
        bus.stall_div = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    bus.stall_div = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    state_nx = (bus.b == 32'd0) ? S_DONE : S_DIV;
`else
                    state_nx = S_DIV;
`endif
                end
            end
            S_DIV: begin
                bus.stall_div = 1'b1;
                if (bus.flush)
                    state_nx = S_IDLE;
                else if (cnt == 6'd31)
                    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            rem      <= 33'd0;
            dvd      <= 32'd0;
            dvs      <= 32'd0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_q <= 64'd0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= 6'd0;
                        rem    <= 33'd0;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        sign_q <= sa ^ sb;
                        sign_r <= sa;
`ifdef DIV_ZERO_FAST_EN
                        if (bus.b == 32'd0) begin
                            result_q <= {bus.a, 32'hFFFF_FFFF};
                            done_q   <= 1'b1;
                        end
`endif
                    end
                end
                S_DIV: begin
                    if (!bus.flush) begin
                        rem <= rem_nx;
                        dvd <= quo_nx;
                        cnt <= cnt + 6'd1;
                        // Sign fixup happens on the final step so result is valid in DONE.
                        if (cnt == 6'd31) begin
                            result_q <= {sign_r ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0],
                                         sign_q ? (32'd0 - quo_nx)       : quo_nx};
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_div_radix2.sv
// Scoreboarded bench for div_radix2: directed DIV/DIVU cases, random vectors,
// divide by zero, flush abort and mid-division reset.
module tb_div_radix2;
    logic clk;
    logic resetn;

    div_radix2_if bus ();

    div_radix2 dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic [63:0] exp_q[$];
    logic [63:0] last_res;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sd, input logic [31:0] av, input logic [31:0] bv);
        logic        sa, sb;
        logic [31:0] ma, mb, q, r;
        sa = sd & av[31];
        sb = sd & bv[31];
        ma = sa ? (32'd0 - av) : av;
        mb = sb ? (32'd0 - bv) : bv;
        if (mb == 32'd0) return {av, 32'hFFFF_FFFF};
        q = ma / mb;
        r = ma % mb;
        if (sa ^ sb) q = 32'd0 - q;
        if (sa) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle lat+1.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] exp, input int lat);
        int got;
        logic [63:0] e;
        got = -1;
        exp_q.push_back(exp);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.a          = av;
        bus.b          = bv;
        @(negedge clk);
        check({tag, "_stall_c0"}, 64'(bus.stall_div), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.start      = 1'b0;
            bus.a          = $urandom;
            bus.b          = $urandom;
            bus.signed_div = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.done) begin
                got = c;
                break;
            end
            if (c == lat - 1) check({tag, "_stall_last"}, 64'(bus.stall_div), 64'd1);
        end
        check({tag, "_latency"}, 64'(got), 64'(lat));
        e = exp_q.pop_front();
        if (got >= 0) begin
            check({tag, "_stall_done"}, 64'(bus.stall_div), 64'd0);
            check({tag, "_result"}, bus.result, e);
            last_res = e;
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sd;
        logic [31:0] av, bv;
        n_checks       = 0;
        n_fail         = 0;
        last_res       = 64'd0;
        resetn         = 1'b0;
        bus.flush      = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done",   64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_stall",  64'(bus.stall_div), 64'd0);
        check("rst_state",  64'(bus.state_dbg), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_div("divu_zero",  1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT);
        run_div("divu_max",   1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);

        for (int i = 0; i < 6; i++) begin
            sd = 1'($urandom_range(0, 1));
            av = $urandom;
            bv = (i < 3) ? 32'($urandom_range(1, 20)) : $urandom;
            if (bv == 32'd0) bv = 32'd3;
            if (i == 5) bv = 32'hFFFF_FFF0 | bv;
            run_div("rand", sd, av, bv, model(sd, av, bv), 33);
        end

        // Flush in cycle 10 of a divide: back to IDLE, result unchanged.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush_state",  64'(bus.state_dbg), 64'd0);
        check("flush_stall",  64'(bus.stall_div), 64'd0);
        check("flush_done",   64'(bus.done), 64'd0);
        check("flush_result", bus.result, last_res);
        @(posedge clk); #1;
        run_div("after_flush", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33);

        // Reset in cycle 20 of a divide, with start held high during reset.
        bus.start = 1'b1; bus.signed_div = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        resetn    = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("mrst_state",  64'(bus.state_dbg), 64'd0);
        check("mrst_result", bus.result, 64'd0);
        check("mrst_done",   64'(bus.done), 64'd0);
        check("mrst_stall",  64'(bus.stall_div), 64'd0);
        @(posedge clk); #1;
        run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, model(1'b1, 32'hFFFF_FF9C, 32'd7), 33);

        if (exp_q.size() != 0) check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative radix-2 restoring divider for the EX stage of the pipelined MIPS core. It consumes the ALU control codes produced in decode and carried into execute: ALU_SIGNED_DIV for DIV and ALU_UNSIGNED_DIV for DIVU. It holds the pipeline while dividing and returns {remainder, quotient} for the HI/LO write. One division runs at a time; the result stays registered until the next start.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- `clk` in 1: sole clock; all state updates on rising edge.
- `resetn` in 1: reset, synchronous and active-low.
- `flush` in 1: pipeline flush (exception/eret); aborts any division.
- `start` in 1: EX holds a DIV/DIVU this cycle; sampled only in IDLE.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a` in 32: dividend (rs), sampled with `start`.
- `b` in 32: divisor (rt), sampled with `start`.
- `stall_div` out 1: combinational; freeze PC/IF/ID/EX while high.
- `done` out 1: registered; high for exactly one cycle when the result becomes valid.
- `result` out 64: registered; [63:32] = remainder (HI), [31:0] = quotient (LO).

## Operation
- States are IDLE, DIV and DONE.
  - IDLE: if `start`, latch |a|, |b| (raw values when unsigned), sign_q = sa^sb, sign_r = sa (both 0 when unsigned). Clear the 6-bit counter and go to DIV.
  - DIV: one restoring step per cycle. Form {rem, dvd} << 1. If rem >= divisor: rem -= divisor and shift in a quotient bit of 1, else shift in 0. After the 32nd step (counter == 31), go to DONE.
  - DONE: `result` <= {sign_r ? -rem : rem, sign_q ? -quo : quo} is registered on entry, so `result` is valid while in DONE. `done` = 1. Next edge goes to IDLE; a new `start` is not accepted in DONE.
- `start` is ignored in DIV and DONE. `a`, `b` and `signed_div` may change freely after the start cycle.
- Arithmetic:
  - Internal remainder is 33 bits. Magnitudes are 32-bit unsigned.
  - abs(0x80000000) = 0x80000000, treated as unsigned.
  - Negation is two's complement, truncated to 32 bits.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural wrap, no trap).
- Divide by zero, macro off: no special path, full 32 steps. Unsigned gives quotient 0xFFFFFFFF, remainder = a. Signed gives whatever the datapath plus sign fixup yields; this case is architecturally UNPREDICTABLE.
- `flush` in any state: next state IDLE, `done` <= 0, `result` unchanged. `flush` takes priority over `start` in the same cycle.
- `resetn` low, sampled at any edge including mid-division: state IDLE, counter 0, `result` = 0, `done` = 0. Reset takes priority over `flush`.

## Timing
- Reset values: `done` = 0, `result` = 64'h0. `stall_div` = 0, because it is combinational from state IDLE with `start` = 0.
- `stall_div` = (IDLE & start & ~flush) | DIV. It is low in DONE, so EX advances in the DONE cycle and the HI/LO write captures `result` there.
- Latency: `start` is high in cycle 0, DIV covers cycles 1–32, DONE is cycle 33.
  - `stall_div` is high for cycles 0–32.
  - `done` and a valid `result` appear in cycle 33.
  - The earliest next `start` is accepted in cycle 34.
- Back-to-back divides therefore need 34 cycles each.

## Configuration
- `DIV_ZERO_FAST_EN` defined: in IDLE with `start` and b == 0, go directly to DONE. Signed and unsigned both give `result` = {a, 32'hFFFFFFFF}. `stall_div` is high in cycle 0 only and `done` is in cycle 1.
- `DIV_ZERO_FAST_EN` undefined: divide by zero takes the normal 33-cycle path with the results described above.

## Test plan
- DIVU a=100, b=7, `start` in cycle 0 → `stall_div` high cycles 0–32, `done` only in cycle 33, `result` = {32'd2, 32'd14}.
- DIV a=-7 (0xFFFFFFF9), b=2 → `result` = {0xFFFFFFFF, 0xFFFFFFFD} (r=-1, q=-3). DIV a=7, b=-2 → {0x00000001, 0xFFFFFFFD}.
- DIV a=0x80000000, b=0xFFFFFFFF → `result` = {0x00000000, 0x80000000}, no hang, `done` in cycle 33.
- DIVU a=5, b=0, macro off → `done` in cycle 33, `result` = {5, 0xFFFFFFFF}. Macro on → `done` in cycle 1, same `result`, `stall_div` high in cycle 0 only.
- Start DIVU 100/7, assert `flush` in cycle 10 → IDLE in cycle 11, `stall_div` low, no `done`, `result` keeps its prior value. New DIVU 9/4 started in cycle 12 → `done` in cycle 45, `result` {1, 2}.
- `resetn` low in cycle 20 of a division → in cycle 21 state IDLE, `result` = 0, `done` = 0, `stall_div` = 0. `start` held high through cycle 20 is ignored while reset is asserted.
